common_clock_packet_fifo: RTL

//   Single-clock store-and-forward packet FIFO.
//   - Write side: valid/ready beat stream with LAST and ERR markers.
//   - A packet becomes visible on the read side only after its LAST beat is accepted without ERR.
//   - Errored packets and packets larger than the FIFO are discarded in place.
//   - Read side is first-word-fall-through, valid/ready.
//   - Placed between packet sources (MACs, DMA) and consumers that must never see partial or bad frames.

---
 rtl/common_clock_packet_fifo.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/common_clock_packet_fifo.sv
// common_clock_packet_fifo
//   Single-clock store-and-forward packet FIFO. Beats are written speculatively
//   and become readable only when the packet's LAST beat arrives without ERR.
//   Errored packets, and packets that would not fit in the buffer, are discarded
//   without ever reaching the read side. The read side is first-word-fall-through
//   through a registered RAM read and a 2-entry output stage.
//
// Ports
//   CLK                  clock, all logic on the rising edge
//   SYNC_RSTN            synchronous reset, active low
//   S_DATA/S_VALID/S_LAST/S_ERR/S_READY   write beat stream (ERR qualifies LAST)
//   M_DATA/M_LAST/M_VALID/M_READY         read beat stream (FWFT)
//   PKT_COUNT            committed packets not yet fully read
//   DATA_COUNT           committed words not yet read (registered, 1-cycle lag)
//   DROP_COUNT           packets dropped since reset, saturating
//   PROG_FULL_THRESHOLD  occupancy threshold, bits [AW:0] used
//   PROG_FULL            registered occupancy >= threshold
module common_clock_packet_fifo #(
    parameter  int FIFO_DEPTH = 8,
    parameter  int DATA_WIDTH = 32,
    localparam int DEPTH      = (FIFO_DEPTH <= 8) ? 8 : (1 << $clog2(FIFO_DEPTH)),
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  SYNC_RSTN,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    input  logic                  S_VALID,
    input  logic                  S_LAST,
    input  logic                  S_ERR,
    output logic                  S_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_LAST,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [AW:0]           PKT_COUNT,
    output logic [31:0]           DATA_COUNT,
    output logic [15:0]           DROP_COUNT,
    input  logic [31:0]           PROG_FULL_THRESHOLD,
    output logic                  PROG_FULL
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } wstate_e;

    logic [DATA_WIDTH:0] mem [DEPTH];

    wstate_e             state_q, state_d;
    logic                rdy_en_q;
    logic [AW:0]         wp_s_q, wp_s_d;
    logic [AW:0]         wp_c_q, wp_c_d;
    logic [AW:0]         rp_q, rp_d;
    logic [AW:0]         cp_q, cp_d;
    logic [AW:0]         pkt_cnt_q, pkt_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [AW:0]         data_cnt_q;
    logic                prog_full_q;

    logic                ram_vld_q;
    logic [DATA_WIDTH:0] ram_q;
    logic [1:0]          ocnt_q, ocnt_d;
    logic [DATA_WIDTH:0] s0_q, s0_d;
    logic [DATA_WIDTH:0] s1_q, s1_d;

    logic [AW:0]         occ;
    logic [AW:0]         pkt_words;
    logic                buf_full;
    logic                pkt_full;
    logic                s_ready;
    logic                s_acc;
    logic                m_acc;
    logic                pop_last;
    logic                rd_issue;
    logic                mem_we;
    logic                commit;
    logic                drop_inc;
    logic                unused_thr;

    assign unused_thr = ^PROG_FULL_THRESHOLD[31:AW+1];

    // Occupancy is measured against the consumer pointer cp (rp minus the words
    // sitting in the RAM read register and output stage), so the total amount of
    // buffered data, including the output stage, never exceeds DEPTH words.
    assign occ       = wp_s_q - cp_q;
    assign pkt_words = wp_s_q - wp_c_q;
    assign buf_full  = (occ == DEPTH_W);
    assign pkt_full  = (pkt_words == DEPTH_W);

    // When the open packet alone fills the buffer it can never commit, so the
    // next beat is still accepted and the packet is dropped instead of stalling.
    assign s_ready = rdy_en_q & ((state_q == DISCARD) | ~buf_full | pkt_full);
    assign s_acc   = S_VALID & s_ready;

    assign m_acc    = (ocnt_q != 2'd0) & M_READY;
    assign pop_last = m_acc & s0_q[DATA_WIDTH];

    // Issue a RAM read only if the beat will have a free output slot when it
    // lands one cycle later, even if the consumer stalls from then on.
    assign rd_issue = (rp_q != wp_c_q) &&
                      (({1'b0, ocnt_q} + {2'b00, ram_vld_q} - {2'b00, m_acc}) <= 3'd1);

    always_comb begin
        state_d  = state_q;
        wp_s_d   = wp_s_q;
        wp_c_d   = wp_c_q;
        mem_we   = 1'b0;
        commit   = 1'b0;
        drop_inc = 1'b0;
        if (s_acc) begin
            if (state_q == DISCARD) begin
                if (S_LAST) begin
                    drop_inc = 1'b1;
                    state_d  = PASS;
                end
            end else if (pkt_full) begin
                wp_s_d = wp_c_q;
                if (S_LAST) begin
                    drop_inc = 1'b1;
                end else begin
                    state_d = DISCARD;
                end
            end else begin
                mem_we = 1'b1;
                wp_s_d = wp_s_q + PTR_ONE;
                if (S_LAST && !S_ERR) begin
                    wp_c_d = wp_s_q + PTR_ONE;
                    commit = 1'b1;
                end else if (S_LAST) begin
                    wp_s_d   = wp_c_q;
                    drop_inc = 1'b1;
                end
            end
        end
    end

    // Output stage: s0 is the presented head, s1 the skid entry.
    always_comb begin
        s0_d   = s0_q;
        s1_d   = s1_q;
        ocnt_d = ocnt_q;
        case ({m_acc, ram_vld_q})
            2'b01: begin
                if (ocnt_q == 2'd0) begin
                    s0_d = ram_q;
                end else begin
                    s1_d = ram_q;
                end
                ocnt_d = ocnt_q + 2'd1;
            end
            2'b10: begin
                s0_d   = s1_q;
                ocnt_d = ocnt_q - 2'd1;
            end
            2'b11: begin
                if (ocnt_q == 2'd1) begin
                    s0_d = ram_q;
                end else begin
                    s0_d = s1_q;
                    s1_d = ram_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (commit && !pop_last) begin
            pkt_cnt_d = pkt_cnt_q + PTR_ONE;
        end else if (!commit && pop_last) begin
            pkt_cnt_d = pkt_cnt_q - PTR_ONE;
        end
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        rp_d = rd_issue ? (rp_q + PTR_ONE) : rp_q;
        cp_d = m_acc ? (cp_q + PTR_ONE) : cp_q;
    end

    always_ff @(posedge CLK) begin
        if (!SYNC_RSTN) begin
            state_q     <= PASS;
            rdy_en_q    <= 1'b0;
            wp_s_q      <= '0;
            wp_c_q      <= '0;
            rp_q        <= '0;
            cp_q        <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            data_cnt_q  <= '0;
            prog_full_q <= 1'b0;
            ram_vld_q   <= 1'b0;
            ocnt_q      <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            wp_s_q      <= wp_s_d;
            wp_c_q      <= wp_c_d;
            rp_q        <= rp_d;
            cp_q        <= cp_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            data_cnt_q  <= wp_c_q - cp_q;
            prog_full_q <= (occ >= PROG_FULL_THRESHOLD[AW:0]);
            ram_vld_q   <= rd_issue;
            ocnt_q      <= ocnt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
        end
    end

    // Storage array and its registered read port carry no reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[wp_s_q[AW-1:0]] <= {S_LAST, S_DATA};
        end
        if (rd_issue) begin
            ram_q <= mem[rp_q[AW-1:0]];
        end
    end

    assign S_READY    = s_ready;
    assign M_DATA     = s0_q[DATA_WIDTH-1:0];
    assign M_LAST     = s0_q[DATA_WIDTH];
    assign M_VALID    = (ocnt_q != 2'd0);
    assign PKT_COUNT  = pkt_cnt_q;
    assign DATA_COUNT = {{(31 - AW){1'b0}}, data_cnt_q};
    assign DROP_COUNT = drop_cnt_q;
    assign PROG_FULL  = prog_full_q;

endmodule
